// File: rtl/prime_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prime_seq_ctrl : sequences the trial-division primality datapath (a1..a7) |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module prime_seq_ctrl #(
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  n,
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  K,
  output logic          a1,
  output logic          a2,
  output logic          a3,
  output logic          a4,
  output logic          a5,
  output logic          a6,
  output logic          a7,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] sub_cycles
);

  localparam logic [2:0]    c_IDLE    = 3'd0;
  localparam logic [2:0]    c_LOAD    = 3'd1;
  localparam logic [2:0]    c_SUB     = 3'd2;
  localparam logic [2:0]    c_RESULT  = 3'd3;
  localparam logic [2:0]    c_DONE    = 3'd4;
  localparam logic [CW-1:0] c_SUB_MAX = {CW{1'b1}};

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [CW-1:0] r_sub_cycles;

  logic w_a_lt_k;
  logic w_a_is_zero;
  logic w_k_is_one;
  logic w_n_lt_two;

  assign w_a_lt_k    = (A < K);
  assign w_a_is_zero = (A == '0);
  assign w_k_is_one  = (K == W'(1));
  assign w_n_lt_two  = (n < W'(2));

  // Selects are decoded from the registered state and datapath only; start
  // influences nothing but the next-state choice.
  always_comb begin
    w_next = r_state;
    a1     = 1'b0;
    a2     = 1'b1;
    a3     = 1'b0;
    a4     = 1'b1;
    a5     = 1'b0;
    a6     = 1'b1;
    a7     = 1'b1;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (start) w_next = c_LOAD;
      end
      c_LOAD: begin
        busy   = 1'b1;
        a2     = 1'b0;
        a6     = 1'b0;
        w_next = w_n_lt_two ? c_RESULT : c_SUB;
      end
      c_SUB: begin
        busy = 1'b1;
        if (!w_a_lt_k) begin
          a1 = 1'b1;
        end else begin
          // Remainder reached: capture it, reload A, step to the next divisor.
          a4 = 1'b0;
          a2 = 1'b0;
          a3 = 1'b1;
          if (w_a_is_zero) begin
            a6 = 1'b0;
            a5 = 1'b1;
          end
          if (w_k_is_one) w_next = c_RESULT;
        end
      end
      c_RESULT: begin
        busy   = 1'b1;
        a7     = 1'b0;
        w_next = c_DONE;
      end
      c_DONE: begin
        done = 1'b1;
        if (!start) w_next = c_IDLE;
      end
      default: begin
        w_next = c_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_IDLE;
      r_sub_cycles <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == c_LOAD) begin
        r_sub_cycles <= '0;
      end else if (r_state == c_SUB && r_sub_cycles != c_SUB_MAX) begin
        r_sub_cycles <= r_sub_cycles + CW'(1);
      end
    end
  end

  assign sub_cycles = r_sub_cycles;

endmodule
`default_nettype wire

// File: tb/tb_prime_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_prime_seq_ctrl : datapath model plus trial-division reference checks   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_prime_seq_ctrl;
  localparam int W  = 8;
  localparam int CW = 16;
  localparam logic [6:0] c_HOLD = 7'b0101011;
  localparam logic [6:0] c_LOAD = 7'b0001001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  n = '0;
  logic          a1, a2, a3, a4, a5, a6, a7;
  logic          busy, done;
  logic [CW-1:0] sub_cycles;

  logic [W-1:0] dp_a = '0;
  logic [W-1:0] dp_k = '0;
  logic [W-1:0] dp_e = '0;
  logic [W-1:0] dp_c = '0;
  logic         dp_p = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  prime_seq_ctrl #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n(n), .A(dp_a), .K(dp_k),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7),
    .busy(busy), .done(done), .sub_cycles(sub_cycles)
  );

  always #5 clk = ~clk;

  // Datapath registers respond to the selects exactly as the datapath would.
  always @(posedge clk) begin
    dp_a <= a1 ? dp_a - dp_k : n;
    dp_k <= a2 ? dp_k : (a3 ? dp_k - W'(1) : n - W'(1));
    dp_e <= a4 ? dp_e : dp_a;
    dp_c <= a6 ? dp_c : (a5 ? dp_c + W'(1) : W'(1));
    dp_p <= a7 ? dp_p : (dp_c == W'(2));
  end

  function automatic logic [6:0] sel();
    return {a1, a2, a3, a4, a5, a6, a7};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: for each divisor K=n-1..1, floor(n/K) subtractions plus one
  // remainder cycle; C counts divisors in [1,n-1] starting from 1.
  task automatic model(input int nv, output int exp_sub, output int exp_c);
    exp_sub = 0;
    exp_c   = 1;
    if (nv >= 2) begin
      for (int k = nv - 1; k >= 1; k--) begin
        exp_sub += nv / k + 1;
        if (nv % k == 0) exp_c++;
      end
    end
  endtask

  task automatic run(input int nv, input bit hold, input string tag);
    int exp_sub, exp_c, lat, bound;
    model(nv, exp_sub, exp_c);
    bound = exp_sub + 20;
    @(negedge clk);
    n     = W'(nv);
    start = 1'b1;
    @(negedge clk);
    check({tag, "_load_sel"}, 32'(sel()), 32'(c_LOAD));
    check({tag, "_load_busy"}, 32'(busy), 32'd1);
    if (!hold) start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < bound) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_sub + 2));
    check({tag, "_sub_cycles"}, 32'(sub_cycles), 32'(exp_sub));
    check({tag, "_C"}, 32'(dp_c), 32'(exp_c));
    check({tag, "_P"}, 32'(dp_p), 32'(exp_c == 2));
    check({tag, "_done_busy"}, 32'(busy), 32'd0);
    check({tag, "_done_sel"}, 32'(sel()), 32'(c_HOLD));
    if (hold) begin
      repeat (4) begin
        @(negedge clk);
        check({tag, "_held_done"}, 32'({done, busy}), 32'b10);
      end
      check({tag, "_held_frozen"}, 32'(sub_cycles), 32'(exp_sub));
      start = 1'b0;
    end
    @(negedge clk);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_sel", 32'(sel()), 32'(c_HOLD));
    check("reset_flags", 32'({busy, done}), 32'd0);
    check("reset_sub_cycles", 32'(sub_cycles), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_sel", 32'(sel()), 32'(c_HOLD));

    run(2, 1'b0, "n2");
    run(3, 1'b0, "n3");
    run(4, 1'b0, "n4");
    run(1, 1'b0, "n1");
    run(0, 1'b0, "n0");
    run(7, 1'b1, "hold7");

    // Abort a long run part-way through SUB.
    @(negedge clk);
    n     = W'(251);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_sel", 32'(sel()), 32'(c_HOLD));
    check("abort_flags", 32'({busy, done}), 32'd0);
    check("abort_sub_cycles", 32'(sub_cycles), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(251, 1'b0, "rerun251");

    for (int i = 0; i < 6; i++) begin
      run(int'($urandom_range(0, 60)), 1'(i % 2), "rand");
    end
    run(255, 1'b0, "n255");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
